gmii_burst_generator: RTL and testbench

//  Next-generation GMII traffic source. Replays a frame template from an internal 32-bit buffer
//  and adds optional preamble/SFD, an optional per-frame sequence number and an optional FCS.

---
 rtl/gmii_burst_generator.sv | 232 +++++++++++++++++++++++
 tb/tb_gmii_burst_generator.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_burst_generator.sv
// GMII burst traffic source: replays a 32-bit-wide frame template with optional
// preamble/SFD, an in-payload sequence number and Ethernet FCS. Frames are sent
// in bursts, with an interframe gap between frames and an interburst gap after
// the last frame of each burst.
module gmii_burst_generator #(
  parameter int unsigned BUF_ADDR_WIDTH = 9,
  parameter int unsigned GAP_WIDTH      = 32,
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter bit          PREAMBLE_EN    = 1'b1,
  parameter bit          FCS_EN         = 1'b1,
  parameter bit          SEQ_EN         = 1'b1,
  parameter int unsigned SEQ_OFFSET     = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      buf_wr,
  input  logic [BUF_ADDR_WIDTH-1:0] buf_addr,
  input  logic [31:0]               buf_wdata,
  input  logic                      run,
  input  logic [15:0]               cfg_frame_size,
  input  logic [GAP_WIDTH-1:0]      cfg_ifg,
  input  logic [GAP_WIDTH-1:0]      cfg_burst_gap,
  input  logic [COUNT_WIDTH-1:0]    cfg_frames_per_burst,
  input  logic [COUNT_WIDTH-1:0]    cfg_total_frames,
  output logic [7:0]                gmii_d,
  output logic                      gmii_en,
  output logic                      gmii_er,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    frames_sent
);

  localparam int unsigned BUF_DEPTH = 1 << BUF_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, PRE, DATA, FCS, IFG, BGAP} state_t;

  state_t                    state, state_n;
  logic [15:0]               bcnt, bcnt_n;
  logic [GAP_WIDTH-1:0]      gap_cnt, gap_n;
  logic [31:0]               crc, crc_n;
  logic [COUNT_WIDTH-1:0]    fs_n, burst_cnt, burst_n;
  logic [15:0]               size_r, size_n;
  logic [GAP_WIDTH-1:0]      ifg_r, ifg_n, bgap_r, bgap_n;
  logic                      run_q, run_qq, rise_pend, pend_n;

  logic [31:0]               mem [BUF_DEPTH];
  logic [31:0]               rd_word;
  logic [BUF_ADDR_WIDTH-1:0] rd_addr_c;

  logic                      run_rise_c, gap_done_c, clr_c, start_ok_c;
  logic                      launch_c, eof_c;
  logic [COUNT_WIDTH-1:0]    fs_eff_c;
  logic [7:0]                d_c, data_byte_c, fcs_byte_c;
  logic [1:0]                seq_idx_c;

  // Big-endian byte pick: index 0 selects bits [31:24]
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Reflected CRC-32 update, one byte, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Template buffer: write port plus registered read of the prefetched address
  always_ff @(posedge clk) begin
    if (buf_wr) mem[buf_addr] <= buf_wdata;
    rd_word <= mem[rd_addr_c];
  end

  // Fetch the word holding the byte sent next cycle; outside DATA the next byte is 0
  assign rd_addr_c = (state == DATA) ? BUF_ADDR_WIDTH'((32'(bcnt) + 32'd1) >> 2) : '0;

  assign run_rise_c = run_q & ~run_qq;
  assign gap_done_c = ((state == IFG) || (state == BGAP)) && (gap_cnt <= GAP_WIDTH'(1));
  assign clr_c      = ((state == IDLE) || gap_done_c) && (rise_pend || run_rise_c);
  assign fs_eff_c   = clr_c ? '0 : frames_sent;
  assign start_ok_c = run_q && (cfg_frame_size != 16'd0) &&
                      ((cfg_total_frames == '0) || (fs_eff_c < cfg_total_frames));

  // Payload byte: template data, overlaid by the sequence number field
  always_comb begin
    data_byte_c = sel_byte(rd_word, bcnt[1:0]);
    seq_idx_c   = 2'(32'(bcnt) - SEQ_OFFSET);
    if (SEQ_EN && (32'(bcnt) >= SEQ_OFFSET) && (32'(bcnt) < SEQ_OFFSET + 32'd4)) begin
      data_byte_c = sel_byte(32'(frames_sent), seq_idx_c);
    end
  end

  // FCS goes out low byte first
  assign fcs_byte_c = sel_byte(~crc, 2'd3 - bcnt[1:0]);

  // Next-state and datapath update
  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    gap_n    = gap_cnt;
    crc_n    = crc;
    fs_n     = frames_sent;
    burst_n  = burst_cnt;
    size_n   = size_r;
    ifg_n    = ifg_r;
    bgap_n   = bgap_r;
    pend_n   = rise_pend | run_rise_c;
    d_c      = 8'h00;
    launch_c = 1'b0;
    eof_c    = 1'b0;

    unique case (state)
      IDLE: launch_c = start_ok_c;
      PRE: begin
        d_c = (bcnt == 16'd7) ? 8'hD5 : 8'h55;
        if (bcnt == 16'd7) begin
          state_n = DATA;
          bcnt_n  = '0;
        end else begin
          bcnt_n = bcnt + 16'd1;
        end
      end
      DATA: begin
        d_c   = data_byte_c;
        crc_n = crc_byte(crc, data_byte_c);
        if (bcnt == size_r - 16'd1) begin
          if (FCS_EN) begin
            state_n = FCS;
            bcnt_n  = '0;
          end else begin
            eof_c = 1'b1;
          end
        end else begin
          bcnt_n = bcnt + 16'd1;
        end
      end
      FCS: begin
        d_c = fcs_byte_c;
        if (bcnt == 16'd3) eof_c = 1'b1;
        else               bcnt_n = bcnt + 16'd1;
      end
      IFG, BGAP: begin
        // The gap's last cycle launches the next frame directly when allowed
        if (gap_done_c) begin
          launch_c = start_ok_c;
          state_n  = IDLE;
        end else begin
          gap_n = gap_cnt - GAP_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (clr_c) begin
      fs_n    = '0;
      burst_n = '0;
      pend_n  = 1'b0;
    end

    if (eof_c) begin
      fs_n = frames_sent + COUNT_WIDTH'(1);
      if ((cfg_frames_per_burst != '0) &&
          ((burst_cnt + COUNT_WIDTH'(1)) >= cfg_frames_per_burst)) begin
        state_n = BGAP;
        burst_n = '0;
        gap_n   = (bgap_r == '0) ? GAP_WIDTH'(1) : bgap_r;
      end else begin
        state_n = IFG;
        burst_n = burst_cnt + COUNT_WIDTH'(1);
        gap_n   = (ifg_r == '0) ? GAP_WIDTH'(1) : ifg_r;
      end
    end

    if (launch_c) begin
      state_n = PREAMBLE_EN ? PRE : DATA;
      bcnt_n  = '0;
      crc_n   = '1;
      size_n  = cfg_frame_size;
      ifg_n   = cfg_ifg;
      bgap_n  = cfg_burst_gap;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bcnt        <= '0;
      gap_cnt     <= '0;
      crc         <= '1;
      frames_sent <= '0;
      burst_cnt   <= '0;
      size_r      <= '0;
      ifg_r       <= '0;
      bgap_r      <= '0;
      run_q       <= 1'b0;
      run_qq      <= 1'b0;
      rise_pend   <= 1'b0;
      gmii_d      <= 8'h00;
      gmii_en     <= 1'b0;
      gmii_er     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bcnt        <= bcnt_n;
      gap_cnt     <= gap_n;
      crc         <= crc_n;
      frames_sent <= fs_n;
      burst_cnt   <= burst_n;
      size_r      <= size_n;
      ifg_r       <= ifg_n;
      bgap_r      <= bgap_n;
      run_q       <= run;
      run_qq      <= run_q;
      rise_pend   <= pend_n;
      gmii_d      <= d_c;
      gmii_en     <= (state == PRE) || (state == DATA) || (state == FCS);
      gmii_er     <= 1'b0;
      busy        <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_gmii_burst_generator.sv
// Bench for gmii_burst_generator: random templates/configs checked against a
// frame-level reference model (byte list, CRC table, gap arithmetic).
module tb_gmii_burst_generator;

  localparam int SEQ_OFF = 14;

  logic        clk;
  logic        rst;
  logic        buf_wr, buf_wr2;
  logic [8:0]  buf_addr;
  logic [3:0]  buf_addr2;
  logic [31:0] buf_wdata, buf_wdata2;
  logic        run, run2;
  logic [15:0] cfg_frame_size, cfg_frame_size2;
  logic [31:0] cfg_ifg, cfg_ifg2, cfg_burst_gap, cfg_burst_gap2;
  logic [31:0] cfg_frames_per_burst, cfg_frames_per_burst2;
  logic [31:0] cfg_total_frames, cfg_total_frames2;
  logic [7:0]  gmii_d, gmii_d2;
  logic        gmii_en, gmii_en2, gmii_er, gmii_er2, busy, busy2;
  logic [31:0] frames_sent, frames_sent2;

  logic        sel;
  logic        mon_en, mon_busy;
  logic [7:0]  mon_d;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int er_hits   = 0;

  logic [7:0]  tmpl [2][2048];
  logic [31:0] crc_tab [256];
  logic [7:0]  cap_q[$];
  logic [7:0]  exp_q[$];

  gmii_burst_generator u_dut (
    .clk(clk), .rst(rst), .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .run(run), .cfg_frame_size(cfg_frame_size), .cfg_ifg(cfg_ifg),
    .cfg_burst_gap(cfg_burst_gap), .cfg_frames_per_burst(cfg_frames_per_burst),
    .cfg_total_frames(cfg_total_frames), .gmii_d(gmii_d), .gmii_en(gmii_en),
    .gmii_er(gmii_er), .busy(busy), .frames_sent(frames_sent)
  );

  gmii_burst_generator #(
    .BUF_ADDR_WIDTH(4), .PREAMBLE_EN(1'b0), .FCS_EN(1'b0), .SEQ_EN(1'b0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .buf_wr(buf_wr2), .buf_addr(buf_addr2), .buf_wdata(buf_wdata2),
    .run(run2), .cfg_frame_size(cfg_frame_size2), .cfg_ifg(cfg_ifg2),
    .cfg_burst_gap(cfg_burst_gap2), .cfg_frames_per_burst(cfg_frames_per_burst2),
    .cfg_total_frames(cfg_total_frames2), .gmii_d(gmii_d2), .gmii_en(gmii_en2),
    .gmii_er(gmii_er2), .busy(busy2), .frames_sent(frames_sent2)
  );

  assign mon_en   = sel ? gmii_en2 : gmii_en;
  assign mon_d    = sel ? gmii_d2  : gmii_d;
  assign mon_busy = sel ? busy2    : busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gmii_er must never rise on either instance
  always @(negedge clk) if (gmii_er || gmii_er2) er_hits++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int gap_exp(input int k, input int fpb, input int ifg, input int bgap);
    int g;
    g = ((fpb != 0) && (((k + 1) % fpb) == 0)) ? bgap : ifg;
    return (g < 1) ? 1 : g;
  endfunction

  // Expected wire bytes of one frame
  function automatic void build_exp(input int which, input int size, input logic [31:0] seqv,
                                    input bit pre, input bit fcs, input bit seq, input int bufbytes);
    logic [7:0]  b;
    logic [31:0] c;
    exp_q.delete();
    if (pre) begin
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
    end
    c = 32'hFFFFFFFF;
    for (int i = 0; i < size; i++) begin
      b = tmpl[which][i % bufbytes];
      if (seq && (i >= SEQ_OFF) && (i < SEQ_OFF + 4)) b = 8'(seqv >> (8 * (SEQ_OFF + 3 - i)));
      exp_q.push_back(b);
      c = (c >> 8) ^ crc_tab[8'(c ^ 32'(b))];
    end
    if (fcs) begin
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(c >> (8 * k)));
    end
  endfunction

  task automatic load_tmpl(input int which, input bit ramp);
    int nw;
    nw = (which == 0) ? 64 : 16;
    for (int i = 0; i < nw * 4; i++) tmpl[which][i] = ramp ? 8'(i) : 8'($urandom);
    for (int w = 0; w < nw; w++) begin
      if (which == 0) begin
        buf_wr = 1'b1; buf_addr = 9'(w);
        buf_wdata = {tmpl[0][4*w], tmpl[0][4*w+1], tmpl[0][4*w+2], tmpl[0][4*w+3]};
      end else begin
        buf_wr2 = 1'b1; buf_addr2 = 4'(w);
        buf_wdata2 = {tmpl[1][4*w], tmpl[1][4*w+1], tmpl[1][4*w+2], tmpl[1][4*w+3]};
      end
      @(negedge clk);
    end
    buf_wr = 1'b0; buf_wr2 = 1'b0;
  endtask

  // Counts en-low cycles from the current negedge until en rises (bounded)
  task automatic wait_frame(input int budget, output int idle, output bit ok);
    idle = 0; ok = 1'b0;
    while (!ok && idle < budget) begin
      if (mon_en) ok = 1'b1;
      else begin idle++; @(negedge clk); end
    end
  endtask

  task automatic grab_frame(input int budget, input int drop_at, output int idle, output bit ok);
    cap_q.delete();
    wait_frame(budget, idle, ok);
    if (ok) begin
      int n;
      n = 0;
      while (mon_en && n < 4096) begin
        cap_q.push_back(mon_d);
        n++;
        if (n == drop_at) run = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    int mis;
    mis = 0;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) if (cap_q[i] !== exp_q[i]) mis++;
    check_val({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    check_val({tag, "_bytes"}, 32'(mis), 32'd0);
  endtask

  task automatic count_busy(input int budget, output int n);
    n = 0;
    while (mon_busy && n < budget) begin n++; @(negedge clk); end
  endtask

  task automatic watch_quiet(input int cycles, output int en_hi, output int busy_hi);
    en_hi = 0; busy_hi = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (mon_en) en_hi++;
      if (mon_busy) busy_hi++;
    end
  endtask

  // One finite run on the full-featured instance: frames, gaps, counters
  task automatic run_burst(input int total, input int fpb, input int ifg, input int bgap,
                           input int size, input string nm);
    int idle, n, enh, bh;
    bit ok;
    cfg_total_frames = 32'(total); cfg_frames_per_burst = 32'(fpb);
    cfg_ifg = 32'(ifg); cfg_burst_gap = 32'(bgap); cfg_frame_size = 16'(size);
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < total; k++) begin
      grab_frame(400, 0, idle, ok);
      check_val($sformatf("%s_f%0d_seen", nm, k), 32'(ok), 32'd1);
      if (k == 0) check_val($sformatf("%s_latency", nm), 32'(idle), 32'd2);
      else check_val($sformatf("%s_gap%0d", nm, k - 1), 32'(idle), 32'(gap_exp(k - 1, fpb, ifg, bgap)));
      build_exp(0, size, 32'(k), 1'b1, 1'b1, 1'b1, 2048);
      compare_frame($sformatf("%s_f%0d", nm, k));
    end
    count_busy(400, n);
    check_val($sformatf("%s_lastgap", nm), 32'(n), 32'(gap_exp(total - 1, fpb, ifg, bgap)));
    check_val($sformatf("%s_frames_sent", nm), frames_sent, 32'(total));
    watch_quiet(30, enh, bh);
    check_val($sformatf("%s_stop_at_total", nm), 32'(enh), 32'd0);
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int idle, n, enh, bh, mis;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] r;
      r = 32'(i);
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      crc_tab[i] = r;
    end
    sel = 1'b0;
    rst = 1'b1; run = 1'b0; run2 = 1'b0;
    buf_wr = 1'b0; buf_addr = '0; buf_wdata = '0;
    buf_wr2 = 1'b0; buf_addr2 = '0; buf_wdata2 = '0;
    cfg_frame_size = '0; cfg_ifg = '0; cfg_burst_gap = '0;
    cfg_frames_per_burst = '0; cfg_total_frames = '0;
    cfg_frame_size2 = '0; cfg_ifg2 = '0; cfg_burst_gap2 = '0;
    cfg_frames_per_burst2 = '0; cfg_total_frames2 = '0;
    repeat (3) @(negedge clk);
    check_val("rst_en", 32'(gmii_en), 32'd0);
    check_val("rst_d", 32'(gmii_d), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_frames_sent", frames_sent, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp template, single 60-byte frame, all modes on
    load_tmpl(0, 1'b1);
    run_burst(1, 0, 12, 0, 60, "t1");

    // Bursts of two with distinct interframe/interburst gaps
    load_tmpl(0, 1'b0);
    run_burst(5, 2, 12, 100, 50, "t2");

    // Random configurations, including frames ending inside the sequence field
    for (int it = 0; it < 5; it++) begin
      run_burst($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 6),
                $urandom_range(0, 20), $urandom_range(1, 70), $sformatf("rnd%0d", it));
    end

    // Unbounded run, run dropped inside the 3rd payload
    cfg_total_frames = 0; cfg_frames_per_burst = 0; cfg_ifg = 4; cfg_frame_size = 16'd40;
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      grab_frame(400, (k == 2) ? 13 : 0, idle, ok);
      check_val($sformatf("t3_f%0d_seen", k), 32'(ok), 32'd1);
      if (k > 0) check_val($sformatf("t3_gap%0d", k - 1), 32'(idle), 32'd4);
      build_exp(0, 40, 32'(k), 1'b1, 1'b1, 1'b1, 2048);
      compare_frame($sformatf("t3_f%0d", k));
    end
    count_busy(100, n);
    check_val("t3_lastgap", 32'(n), 32'd4);
    watch_quiet(100, enh, bh);
    check_val("t3_no_4th_frame", 32'(enh), 32'd0);
    check_val("t3_frames_sent", frames_sent, 32'd3);
    repeat (10) @(negedge clk);
    check_val("t3_frames_sent_hold", frames_sent, 32'd3);

    // New run start clears the frame counter and sequence number
    run_burst(1, 0, 2, 0, 18, "restart");

    // Zero frame size never starts
    cfg_frame_size = 16'd0; cfg_total_frames = 0;
    run = 1'b1;
    watch_quiet(40, enh, bh);
    check_val("t6_en", 32'(enh), 32'd0);
    check_val("t6_busy", 32'(bh), 32'd0);
    check_val("t6_frames_sent", frames_sent, 32'd0);
    run = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a payload byte
    cfg_frame_size = 16'd40; cfg_ifg = 3;
    run = 1'b1;
    @(negedge clk);
    wait_frame(50, idle, ok);
    check_val("t5_seen", 32'(ok), 32'd1);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("t5_en_now", 32'(gmii_en), 32'd0);
    check_val("t5_d_now", 32'(gmii_d), 32'd0);
    check_val("t5_busy_now", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    grab_frame(50, 0, idle, ok);
    check_val("t5_restart_latency", 32'(idle), 32'd2);
    build_exp(0, 40, 32'd0, 1'b1, 1'b1, 1'b1, 2048);
    compare_frame("t5_restart");
    run = 1'b0;
    count_busy(50, n);
    repeat (5) @(negedge clk);

    // Stripped-down instance: size-1 frames back to back with ifg=0
    sel = 1'b1;
    load_tmpl(1, 1'b0);
    cfg_frame_size2 = 16'd1; cfg_ifg2 = 0; cfg_total_frames2 = 0; cfg_frames_per_burst2 = 0;
    run2 = 1'b1;
    @(negedge clk);
    wait_frame(50, idle, ok);
    check_val("t4_latency", 32'(idle), 32'd2);
    mis = 0;
    for (int k = 0; k < 20; k++) begin
      if (mon_en !== ((k % 2) == 0)) mis++;
      if (mon_d !== (((k % 2) == 0) ? tmpl[1][0] : 8'h00)) mis++;
      @(negedge clk);
    end
    check_val("t4_pattern", 32'(mis), 32'd0);
    run2 = 1'b0;
    repeat (10) @(negedge clk);

    // Frame longer than the 64-byte buffer wraps the read address
    cfg_frame_size2 = 16'd100; cfg_ifg2 = 3; cfg_total_frames2 = 1;
    run2 = 1'b1;
    @(negedge clk);
    grab_frame(50, 0, idle, ok);
    check_val("wrap_latency", 32'(idle), 32'd2);
    build_exp(1, 100, 32'd0, 1'b0, 1'b0, 1'b0, 64);
    compare_frame("wrap");
    count_busy(50, n);
    check_val("wrap_gap", 32'(n), 32'd3);
    check_val("wrap_frames_sent", frames_sent2, 32'd1);
    run2 = 1'b0;
    repeat (3) @(negedge clk);

    check_val("er_never", 32'(er_hits), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
